residue_alu_pipe: RTL and testbench
===================================

# residue_alu_pipe

Parametrised, two-stage pipelined simple ALU with residue-code (mod 2^MOD_W−1) self-checking, valid/ready handshakes and a saturating error counter. Sits in the execute stage beside the existing simple ALU lanes and is the successor lane for fault-detection work. Operand residues are predicted in stage 1; the result residue is recomputed and compared in stage 2. Mismatches are flagged per instruction and counted.

## Interface
- DATA_W, 32, operand/result width
- IMM_W, 16, immediate width; sign- or zero-extended to DATA_W
- MOD_W, 5, residue width; modulus M = 2^MOD_W − 1 (MOD_W ≥ 2)
- TAG_W, 8, opaque tag carried alongside each op
- ERR_CNT_W, 8, error counter width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush_i  in  1  kill all in-flight ops
- in_valid_i / in_ready_o  in/out  1  input handshake
- opcode_i  in  `SIZE_OPCODE_I  existing opcode defines
- data1_i, data2_i  in  DATA_W  operands
- immd_i  in  IMM_W  immediate
- tag_i  in  TAG_W  tag
- inject_i  in  1  fault injection: flip result bit 0 in stage 1
- out_valid_o / out_ready_i  out/in  1  output handshake
- result_o  out  DATA_W;  resid_o  out  MOD_W  result residue, normalised
- tag_o  out  TAG_W;  overflow_o  out  1  signed overflow (ADD, ADDI, SUB)
- checked_o  out  1  op was residue-checked;  resid_err_o  out  1  mismatch
- err_count_o  out  ERR_CNT_W  saturating mismatch count

## Operation
- Ops: ADD, ADDU, SUB, SUBU, ADDI, ADDIU (checked); AND_, OR, XOR, NOR, SLL, SRL, SRA, LUI (unchecked). ADDI/ADDIU sign-extend immd_i. Shifts use immd_i[4:0]. Any other opcode gives result 0 and unchecked.
- Residue r(x): zero-pad x to a multiple of MOD_W. Sum the MOD_W-bit chunks with end-around carry. Map all-ones to 0.
- WRAP = 2^(DATA_W mod MOD_W) mod M. With the defaults, WRAP = 4.
- Predicted residue for add: r(a) + r(b) − cout·WRAP (mod M).
- Predicted residue for sub: r(a) − r(b) + (1 − cout)·WRAP (mod M), where cout is the carry of a + ~b + 1.
- Stage 1 registers: result (bit 0 XOR inject_i), predicted residue, cout, overflow, tag, checked.
- Stage 2:
  - Computes r(result) and drives resid_o.
  - resid_err_o = checked & (r(result) ≠ predicted).
- Counter behaviour:
  - err_count_o increments on each output handshake with resid_err_o = 1.
  - It saturates at all-ones.
  - It is cleared only by reset.
- Pipeline:
  - Stage 2 advances when empty or when out_ready_i = 1.
  - Stage 1 advances when empty or when stage 2 advances.
  - in_ready_o = ~flush_i & stage-1 advance condition (combinational).
  - Throughput is one op per cycle.
- flush_i: both stage valids clear on the next edge. An input presented in the same cycle is not accepted. The counter is unaffected by flushed ops.

## Timing
- Op accepted at edge E → held in stage 1 after E → visible at outputs after E+1 when unstalled. Latency is 2 edges.
- Outputs hold stable while out_valid_o = 1 and out_ready_i = 0.
- Reset values: out_valid_o 0, result_o 0, resid_o 0, tag_o 0, overflow_o 0, checked_o 0, resid_err_o 0, err_count_o 0.
- in_ready_o is 1 one cycle after reset deasserts and stays combinational after that.
- Reset asserted mid-operation drops all ops immediately, asynchronously.
- Stall with both stages full → in_ready_o = 0. No op is lost or reordered.

## Configuration
- RESIDUE_CHECK_EN defined:
  - Residue prediction, comparison and the counter are implemented as above.
- RESIDUE_CHECK_EN undefined:
  - Prediction and compare logic are removed.
  - resid_err_o, checked_o and err_count_o are tied to 0.
  - resid_o is still computed.
  - Latency and handshake are unchanged.

## Test plan
- ADDU 0xFFFFFFFF + 0x2 → result_o 0x1, resid_o 1, resid_err_o 0, checked_o 1.
- ADD 0x7FFFFFFF + 0x1 → result_o 0x80000000, overflow_o 1, resid_o 2, resid_err_o 0.
- SUB 3 − 5 → result_o 0xFFFFFFFE, resid_o 2, resid_err_o 0; SUBU 5 − 3 → 0x2, resid_o 2.
- ADDU 10 + 20 with inject_i = 1:
  - With RESIDUE_CHECK_EN: result_o 31, resid_o 0, resid_err_o 1, err_count_o 1 after handshake.
  - Without it: resid_err_o 0.
- Five back-to-back ADDIs (data1 0, immd 1..5) with out_ready_i low for 3 cycles:
  - in_ready_o drops after 2 accepts.
  - Outputs arrive 1..5 in order, tags preserved.
- Two ops in flight, then flush_i for one cycle → out_valid_o 0 next cycle and no outputs appear.
- reset_n pulsed low mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/residue_alu_pipe.sv
// Two-stage ALU lane with mod (2^MOD_W - 1) residue self-checking and valid/ready handshakes.
// Build with RESIDUE_CHECK_EN defined to include residue prediction, comparison and the error counter.

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef ADD
`define ADD   6'd1
`endif
`ifndef ADDU
`define ADDU  6'd2
`endif
`ifndef SUB
`define SUB   6'd3
`endif
`ifndef SUBU
`define SUBU  6'd4
`endif
`ifndef ADDI
`define ADDI  6'd5
`endif
`ifndef ADDIU
`define ADDIU 6'd6
`endif
`ifndef AND_
`define AND_  6'd7
`endif
`ifndef OR
`define OR    6'd8
`endif
`ifndef XOR
`define XOR   6'd9
`endif
`ifndef NOR
`define NOR   6'd10
`endif
`ifndef SLL
`define SLL   6'd11
`endif
`ifndef SRL
`define SRL   6'd12
`endif
`ifndef SRA
`define SRA   6'd13
`endif
`ifndef LUI
`define LUI   6'd14
`endif

module residue_alu_pipe #(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,
  parameter int MOD_W     = 5,
  parameter int TAG_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [`SIZE_OPCODE_I-1:0] opcode_i,
  input  logic [DATA_W-1:0]         data1_i,
  input  logic [DATA_W-1:0]         data2_i,
  input  logic [IMM_W-1:0]          immd_i,
  input  logic [TAG_W-1:0]          tag_i,
  input  logic                      inject_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         result_o,
  output logic [MOD_W-1:0]          resid_o,
  output logic [TAG_W-1:0]          tag_o,
  output logic                      overflow_o,
  output logic                      checked_o,
  output logic                      resid_err_o,
  output logic [ERR_CNT_W-1:0]      err_count_o
);

  localparam int NCHUNK = (DATA_W + MOD_W - 1) / MOD_W;

  // End-around-carry fold of a MOD_W+1 bit sum, with all-ones normalised to zero.
  function automatic logic [MOD_W-1:0] foldMod(input logic [MOD_W:0] s);
    logic [MOD_W-1:0] t;
    t = s[MOD_W-1:0] + MOD_W'(s[MOD_W]);
    return (&t) ? '0 : t;
  endfunction

  function automatic logic [MOD_W-1:0] residue(input logic [DATA_W-1:0] x);
    logic [NCHUNK*MOD_W-1:0] padded;
    logic [MOD_W-1:0]        acc;
    padded = (NCHUNK*MOD_W)'(x);
    acc    = '0;
    for (int i = 0; i < NCHUNK; i++)
      acc = foldMod({1'b0, acc} + {1'b0, padded[i*MOD_W +: MOD_W]});
    return acc;
  endfunction

  logic              s1Valid_q, s1Valid_d;
  logic [DATA_W-1:0] s1Result_q, s1Result_d;
  logic              s1Ovf_q, s1Ovf_d;
  logic [TAG_W-1:0]  s1Tag_q;
  logic              s2Valid_q, s2Valid_d;
  logic [DATA_W-1:0] s2Result_q;
  logic [MOD_W-1:0]  s2Resid_q, s2Resid_d;
  logic              s2Ovf_q;
  logic [TAG_W-1:0]  s2Tag_q;

  logic s2Adv, s1Adv, accept, s2Load;
  logic useImm, isSub, isSigned;
  logic [DATA_W-1:0] immSext, opB, addIn2, sum;
  logic [4:0] shamt;

  assign s2Adv      = ~s2Valid_q | out_ready_i;
  assign s1Adv      = ~s1Valid_q | s2Adv;
  assign in_ready_o = ~flush_i & s1Adv;
  assign accept     = in_valid_i & in_ready_o;
  assign s2Load     = s2Adv & s1Valid_q;

  always_comb begin
    immSext  = {{(DATA_W-IMM_W){immd_i[IMM_W-1]}}, immd_i};
    useImm   = (opcode_i == `ADDI) || (opcode_i == `ADDIU);
    isSub    = (opcode_i == `SUB)  || (opcode_i == `SUBU);
    isSigned = (opcode_i == `ADD)  || (opcode_i == `ADDI) || (opcode_i == `SUB);
    opB      = useImm ? immSext : data2_i;
    addIn2   = isSub ? ~opB : opB;
    sum      = data1_i + addIn2 + DATA_W'(isSub);
    shamt    = immd_i[4:0];
    s1Ovf_d  = isSigned & (data1_i[DATA_W-1] == addIn2[DATA_W-1])
                        & (sum[DATA_W-1] != data1_i[DATA_W-1]);
    case (opcode_i)
      `ADD, `ADDU, `SUB, `SUBU, `ADDI, `ADDIU: s1Result_d = sum;
      `AND_:   s1Result_d = data1_i & data2_i;
      `OR:     s1Result_d = data1_i | data2_i;
      `XOR:    s1Result_d = data1_i ^ data2_i;
      `NOR:    s1Result_d = ~(data1_i | data2_i);
      `SLL:    s1Result_d = data1_i << shamt;
      `SRL:    s1Result_d = data1_i >> shamt;
      `SRA:    s1Result_d = $signed(data1_i) >>> shamt;
      `LUI:    s1Result_d = DATA_W'(immd_i) << (DATA_W - IMM_W);
      default: s1Result_d = '0;
    endcase
    s1Result_d[0] = s1Result_d[0] ^ inject_i;
  end

  always_comb begin
    s1Valid_d = flush_i ? 1'b0 : (s1Adv ? accept : s1Valid_q);
    s2Valid_d = flush_i ? 1'b0 : (s2Adv ? s1Valid_q : s2Valid_q);
    s2Resid_d = residue(s1Result_q);
  end

`ifdef RESIDUE_CHECK_EN
  localparam logic [MOD_W-1:0] WRAP = MOD_W'(2 ** (DATA_W % MOD_W));

  function automatic logic [MOD_W-1:0] modAdd(input logic [MOD_W-1:0] a, input logic [MOD_W-1:0] b);
    return foldMod({1'b0, a} + {1'b0, b});
  endfunction

  function automatic logic [MOD_W-1:0] modSub(input logic [MOD_W-1:0] a, input logic [MOD_W-1:0] b);
    return modAdd(a, ~b);
  endfunction

  logic [MOD_W-1:0]     s1Pred_q, s1Pred_d, finalPred;
  logic                 s1Cout_q, s1Cout_d, s1IsSub_q, s1Checked_q, s1Checked_d;
  logic                 s2Checked_q, s2Err_q, s2Err_d;
  logic [ERR_CNT_W-1:0] errCount_q, errCount_d;

  // Stage 1 predicts from operand residues only; the carry-out correction is applied in stage 2.
  always_comb begin
    s1Cout_d    = (data1_i[DATA_W-1] & addIn2[DATA_W-1])
                | ((data1_i[DATA_W-1] ^ addIn2[DATA_W-1])
                   & (sum[DATA_W-1] ^ data1_i[DATA_W-1] ^ addIn2[DATA_W-1]));
    s1Pred_d    = isSub ? modSub(residue(data1_i), residue(opB))
                        : modAdd(residue(data1_i), residue(opB));
    s1Checked_d = (opcode_i == `ADD) || (opcode_i == `ADDU) || (opcode_i == `SUB)
               || (opcode_i == `SUBU) || (opcode_i == `ADDI) || (opcode_i == `ADDIU);
  end

  always_comb begin
    if (s1IsSub_q) finalPred = s1Cout_q ? s1Pred_q : modAdd(s1Pred_q, WRAP);
    else           finalPred = s1Cout_q ? modSub(s1Pred_q, WRAP) : s1Pred_q;
    s2Err_d    = s1Checked_q & (s2Resid_d != finalPred);
    errCount_d = errCount_q;
    if (s2Valid_q & out_ready_i & s2Err_q & ~(&errCount_q))
      errCount_d = errCount_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Pred_q    <= '0;
      s1Cout_q    <= 1'b0;
      s1IsSub_q   <= 1'b0;
      s1Checked_q <= 1'b0;
      s2Checked_q <= 1'b0;
      s2Err_q     <= 1'b0;
      errCount_q  <= '0;
    end else begin
      errCount_q <= errCount_d;
      if (accept) begin
        s1Pred_q    <= s1Pred_d;
        s1Cout_q    <= s1Cout_d;
        s1IsSub_q   <= isSub;
        s1Checked_q <= s1Checked_d;
      end
      if (s2Load) begin
        s2Checked_q <= s1Checked_q;
        s2Err_q     <= s2Err_d;
      end
    end
  end

  assign checked_o   = s2Checked_q;
  assign resid_err_o = s2Err_q;
  assign err_count_o = errCount_q;
`else
  assign checked_o   = 1'b0;
  assign resid_err_o = 1'b0;
  assign err_count_o = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q  <= 1'b0;
      s1Result_q <= '0;
      s1Ovf_q    <= 1'b0;
      s1Tag_q    <= '0;
      s2Valid_q  <= 1'b0;
      s2Result_q <= '0;
      s2Resid_q  <= '0;
      s2Ovf_q    <= 1'b0;
      s2Tag_q    <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s2Valid_q <= s2Valid_d;
      if (accept) begin
        s1Result_q <= s1Result_d;
        s1Ovf_q    <= s1Ovf_d;
        s1Tag_q    <= tag_i;
      end
      if (s2Load) begin
        s2Result_q <= s1Result_q;
        s2Resid_q  <= s2Resid_d;
        s2Ovf_q    <= s1Ovf_q;
        s2Tag_q    <= s1Tag_q;
      end
    end
  end

  assign out_valid_o = s2Valid_q;
  assign result_o    = s2Result_q;
  assign resid_o     = s2Resid_q;
  assign tag_o       = s2Tag_q;
  assign overflow_o  = s2Ovf_q;

endmodule

// File: tb/tb_residue_alu_pipe.sv
// Directed-vector bench for residue_alu_pipe: opcode table plus stall, flush, saturation and reset sequences.
// Expectations for checked_o / resid_err_o / err_count_o follow whether RESIDUE_CHECK_EN is defined.

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef ADD
`define ADD   6'd1
`endif
`ifndef ADDU
`define ADDU  6'd2
`endif
`ifndef SUB
`define SUB   6'd3
`endif
`ifndef SUBU
`define SUBU  6'd4
`endif
`ifndef ADDI
`define ADDI  6'd5
`endif
`ifndef ADDIU
`define ADDIU 6'd6
`endif
`ifndef AND_
`define AND_  6'd7
`endif
`ifndef OR
`define OR    6'd8
`endif
`ifndef XOR
`define XOR   6'd9
`endif
`ifndef NOR
`define NOR   6'd10
`endif
`ifndef SLL
`define SLL   6'd11
`endif
`ifndef SRL
`define SRL   6'd12
`endif
`ifndef SRA
`define SRA   6'd13
`endif
`ifndef LUI
`define LUI   6'd14
`endif

module tb_residue_alu_pipe;

`ifdef RESIDUE_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif
  localparam int NV = 20;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      flush_i, in_valid_i, in_ready_o, inject_i;
  logic [`SIZE_OPCODE_I-1:0] opcode_i;
  logic [31:0]               data1_i, data2_i, result_o;
  logic [15:0]               immd_i;
  logic [7:0]                tag_i, tag_o, err_count_o;
  logic                      out_valid_o, out_ready_i, overflow_o, checked_o, resid_err_o;
  logic [4:0]                resid_o;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [7:0]  tag;
    logic        inj;
    logic [31:0] res;
    logic [4:0]  rsd;
    logic        ovf;
    logic        chk;
    logic        err;
  } vec_t;

  vec_t vecs[NV];
  int   nApplied = 0;
  int   nMiscompare = 0;
  int   expCount = 0;

  residue_alu_pipe dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .opcode_i(opcode_i),
    .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i), .tag_i(tag_i),
    .inject_i(inject_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .resid_o(resid_o), .tag_o(tag_o), .overflow_o(overflow_o),
    .checked_o(checked_o), .resid_err_o(resid_err_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [7:0] tag, input logic inj);
    opcode_i = op; data1_i = a; data2_i = b; immd_i = imm; tag_i = tag; inject_i = inj;
    in_valid_i = 1'b1;
  endtask

  // One op through an otherwise idle pipe, checking latency and every output field.
  task automatic applyStimulus(input int idx, input vec_t v);
    int k;
    @(negedge clk);
    driveOp(v.op, v.a, v.b, v.imm, v.tag, v.inj);
    #1 checkOutput($sformatf("v%0d in_ready", idx), in_ready_o, 1);
    @(posedge clk);
    #1 in_valid_i = 1'b0; inject_i = 1'b0;
    k = 0;
    while (!out_valid_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput($sformatf("v%0d latency", idx), k, 2);
    checkOutput($sformatf("v%0d result", idx), result_o, v.res);
    checkOutput($sformatf("v%0d resid", idx), resid_o, v.rsd);
    checkOutput($sformatf("v%0d overflow", idx), overflow_o, v.ovf);
    checkOutput($sformatf("v%0d tag", idx), tag_o, v.tag);
    checkOutput($sformatf("v%0d checked", idx), checked_o, v.chk & CHK_EN);
    checkOutput($sformatf("v%0d resid_err", idx), resid_err_o, v.err & CHK_EN);
    checkOutput($sformatf("v%0d err_count", idx), err_count_o, expCount);
    if (v.err & CHK_EN) expCount++;
  endtask

  initial begin
    int sent, rcv;
    logic seen;
    vecs[0]  = '{`ADDU,  32'hFFFFFFFF, 32'h2,        16'h0,    8'h01, 1'b0, 32'h1,        5'd1,  1'b0, 1'b1, 1'b0};
    vecs[1]  = '{`ADD,   32'h7FFFFFFF, 32'h1,        16'h0,    8'h02, 1'b0, 32'h80000000, 5'd2,  1'b1, 1'b1, 1'b0};
    vecs[2]  = '{`SUB,   32'h3,        32'h5,        16'h0,    8'h03, 1'b0, 32'hFFFFFFFE, 5'd2,  1'b0, 1'b1, 1'b0};
    vecs[3]  = '{`SUBU,  32'h5,        32'h3,        16'h0,    8'h04, 1'b0, 32'h2,        5'd2,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{`ADDU,  32'd10,       32'd20,       16'h0,    8'h05, 1'b1, 32'd31,       5'd0,  1'b0, 1'b1, 1'b1};
    vecs[5]  = '{`ADDI,  32'd100,      32'h0,        16'hFFFF, 8'h06, 1'b0, 32'd99,       5'd6,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{`ADDIU, 32'h0,        32'h0,        16'h8000, 8'h07, 1'b0, 32'hFFFF8000, 5'd3,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{`AND_,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0,    8'h08, 1'b0, 32'hF000F000, 5'd25, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{`OR,    32'h12340000, 32'h00005678, 16'h0,    8'h09, 1'b0, 32'h12345678, 5'd22, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{`XOR,   32'hFFFF0000, 32'h0F0F0F0F, 16'h0,    8'h0A, 1'b0, 32'hF0F00F0F, 5'd22, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{`NOR,   32'h0,        32'h0,        16'h0,    8'h0B, 1'b0, 32'hFFFFFFFF, 5'd3,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{`SLL,   32'h1,        32'h0,        16'h001F, 8'h0C, 1'b0, 32'h80000000, 5'd2,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{`SRL,   32'h80000000, 32'h0,        16'h0004, 8'h0D, 1'b0, 32'h08000000, 5'd4,  1'b0, 1'b0, 1'b0};
    vecs[13] = '{`SRA,   32'h80000000, 32'h0,        16'h0004, 8'h0E, 1'b0, 32'hF8000000, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[14] = '{`LUI,   32'h0,        32'h0,        16'hABCD, 8'h0F, 1'b0, 32'hABCD0000, 5'd15, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{6'h3F,  32'h5,        32'h7,        16'h0,    8'h10, 1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b0};
    vecs[16] = '{`SUB,   32'h80000000, 32'h1,        16'h0,    8'h11, 1'b0, 32'h7FFFFFFF, 5'd1,  1'b1, 1'b1, 1'b0};
    vecs[17] = '{`ADD,   32'h1F,       32'h0,        16'h0,    8'h12, 1'b0, 32'h1F,       5'd0,  1'b0, 1'b1, 1'b0};
    vecs[18] = '{`SUBU,  32'h0,        32'h0,        16'h0,    8'h13, 1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 1'b0};
    vecs[19] = '{`ADD,   32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0,    8'h14, 1'b0, 32'hFFFFFFFE, 5'd2,  1'b0, 1'b1, 1'b0};

    reset_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    driveOp(6'h0, 32'h0, 32'h0, 16'h0, 8'h0, 1'b0);
    in_valid_i = 1'b0;
    #12;
    checkOutput("rst out_valid", out_valid_o, 0);
    checkOutput("rst result", result_o, 0);
    checkOutput("rst resid", resid_o, 0);
    checkOutput("rst tag", tag_o, 0);
    checkOutput("rst overflow", overflow_o, 0);
    checkOutput("rst checked", checked_o, 0);
    checkOutput("rst resid_err", resid_err_o, 0);
    checkOutput("rst err_count", err_count_o, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    #1 checkOutput("rst in_ready", in_ready_o, 1);

    for (int i = 0; i < NV; i++) applyStimulus(i, vecs[i]);

    // Five back-to-back ADDIs against a consumer that stalls for the first three cycles.
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 30 && rcv < 5; cyc++) begin
      @(negedge clk);
      out_ready_i = (cyc >= 3);
      if (sent < 5) driveOp(`ADDI, 32'h0, 32'h0, 16'(sent + 1), 8'(8'h40 + sent), 1'b0);
      else in_valid_i = 1'b0;
      #1;
      if (cyc == 2) begin
        checkOutput("stall in_ready", in_ready_o, 0);
        checkOutput("stall accepts", sent, 2);
        checkOutput("stall hold", result_o, 1);
      end
      if (out_valid_o && out_ready_i) begin
        checkOutput($sformatf("stall out%0d result", rcv), result_o, rcv + 1);
        checkOutput($sformatf("stall out%0d tag", rcv), tag_o, 8'h40 + rcv);
        rcv++;
      end
      if (in_valid_i && in_ready_o) sent++;
    end
    checkOutput("stall outputs", rcv, 5);
    @(negedge clk); in_valid_i = 1'b0;

    // Two ops in flight, then a one-cycle flush that also presents a third op.
    out_ready_i = 1'b0;
    driveOp(`ADDU, 32'h1, 32'h1, 16'h0, 8'h50, 1'b0);
    @(negedge clk);
    driveOp(`ADDU, 32'h2, 32'h2, 16'h0, 8'h51, 1'b0);
    @(negedge clk);
    driveOp(`ADDU, 32'h3, 32'h3, 16'h0, 8'h52, 1'b0);
    flush_i = 1'b1;
    #1 checkOutput("flush in_ready", in_ready_o, 0);
    checkOutput("flush pre out_valid", out_valid_o, 1);
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    #1 checkOutput("flush out_valid", out_valid_o, 0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    checkOutput("flush no outputs", seen, 0);
    checkOutput("flush err_count", err_count_o, expCount);

`ifdef RESIDUE_CHECK_EN
    // Stream enough faulty ops to pin the counter at all-ones.
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 260; cyc++) begin
      @(negedge clk);
      driveOp(`ADDU, 32'd10, 32'd20, 16'h0, 8'h60, 1'b1);
      #1 if (in_ready_o) sent++;
    end
    @(negedge clk); in_valid_i = 1'b0; inject_i = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    checkOutput("sat err_count", err_count_o, 8'hFF);
`endif

    // Asynchronous reset while an op sits in the output stage.
    out_ready_i = 1'b0;
    driveOp(`ADD, 32'h7FFFFFFF, 32'h1, 16'h0, 8'hAA, 1'b1);
    @(negedge clk); in_valid_i = 1'b0; inject_i = 1'b0;
    @(negedge clk);
    #1 checkOutput("prereset out_valid", out_valid_o, 1);
    checkOutput("prereset tag", tag_o, 8'hAA);
    #2 reset_n = 1'b0;
    #1 checkOutput("arst out_valid", out_valid_o, 0);
    checkOutput("arst result", result_o, 0);
    checkOutput("arst tag", tag_o, 0);
    checkOutput("arst overflow", overflow_o, 0);
    checkOutput("arst resid_err", resid_err_o, 0);
    checkOutput("arst err_count", err_count_o, 0);
    @(negedge clk); reset_n = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    #1 checkOutput("arst in_ready", in_ready_o, 1);
    checkOutput("arst stays empty", out_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
